// File: rtl/sub_serial2_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM encoding and digit width.
package sub_serial2_pkg;

   localparam int DIGIT_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

endpackage

// File: rtl/sub2_slice.sv
// Combinational 2-bit subtract slice: a + ~b + borrow_n, with active-low borrows.
module sub2_slice
   import sub_serial2_pkg::*;
(
   input  logic [DIGIT_W-1:0] a_i,
   input  logic [DIGIT_W-1:0] b_i,
   input  logic               bi_n_i,
   output logic [DIGIT_W-1:0] diff_o,
   output logic [DIGIT_W-1:0] bo_n_o
);

   logic c;

   // NOTE: every output gets a default before the loop so no path can infer a latch.
   always_comb begin
      diff_o = '0;
      bo_n_o = '0;
      c      = bi_n_i;
      for (int i = 0; i < DIGIT_W; i++) begin
         diff_o[i] = a_i[i] ^ ~b_i[i] ^ c;
         bo_n_o[i] = (a_i[i] & ~b_i[i]) | (c & (a_i[i] ^ ~b_i[i]));
         c         = bo_n_o[i];
      end
   end

endmodule

// File: rtl/sub_serial2.sv
// Digit-serial subtractor, 2 bits per cycle, LSB first; DIFF = A + ~B + BI.
// Optional ZERO result flag enabled by defining SUB_SERIAL2_ZERO_FLAG_EN.
module sub_serial2
   import sub_serial2_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             BI,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] DIFF,
   output logic             BOUT
`ifdef SUB_SERIAL2_ZERO_FLAG_EN
   ,
   output logic             ZERO
`endif
);

   localparam int DIGITS = WIDTH / DIGIT_W;
   localparam int CNT_W  = $clog2(DIGITS) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, diff_q, diff_d;
   logic               borrow_q, borrow_d, bout_q, bout_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DIGIT_W-1:0] slice_diff, slice_bo;
   logic               unused_bo;
`ifdef SUB_SERIAL2_ZERO_FLAG_EN
   logic               zero_q, zero_d;
`endif

   sub2_slice u_slice (
      .a_i    (a_q[DIGIT_W-1:0]),
      .b_i    (b_q[DIGIT_W-1:0]),
      .bi_n_i (borrow_q),
      .diff_o (slice_diff),
      .bo_n_o (slice_bo)
   );

   assign unused_bo = slice_bo[0];

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      bout_d   = bout_q;
`ifdef SUB_SERIAL2_ZERO_FLAG_EN
      zero_d   = zero_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               a_d      = A;
               b_d      = B;
               borrow_d = BI;
               cnt_d    = '0;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            a_d      = a_q >> DIGIT_W;
            b_d      = b_q >> DIGIT_W;
            borrow_d = slice_bo[DIGIT_W-1];
            // Result digits enter at the MSB end so the LSB digit lands at bit 0 after the last shift.
            diff_d   = WIDTH'({slice_diff, diff_q} >> DIGIT_W);
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
               state_d = ST_FIN;
               bout_d  = slice_bo[DIGIT_W-1];
`ifdef SUB_SERIAL2_ZERO_FLAG_EN
               zero_d  = (diff_d == '0);
`endif
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; RST wins over any START.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
`ifdef SUB_SERIAL2_ZERO_FLAG_EN
         zero_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         bout_q   <= bout_d;
`ifdef SUB_SERIAL2_ZERO_FLAG_EN
         zero_q   <= zero_d;
`endif
      end
   end

   assign BUSY = (state_q != ST_IDLE);
   assign DONE = (state_q == ST_FIN);
   assign DIFF = diff_q;
   assign BOUT = bout_q;
`ifdef SUB_SERIAL2_ZERO_FLAG_EN
   assign ZERO = zero_q;
`endif

endmodule

// File: tb/tb_sub_serial2.sv
// Directed bench for sub_serial2 (WIDTH=16) with a scoreboard queue of expected {BOUT, DIFF}.
module tb_sub_serial2;

   localparam int W = 16;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         START = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         BI = 1'b0;
   logic         BUSY, DONE, BOUT;
   logic [W-1:0] DIFF;
`ifdef SUB_SERIAL2_ZERO_FLAG_EN
   logic         ZERO;
`endif

   int total = 0;
   int bad   = 0;
   logic [W:0] sb_q[$];

   sub_serial2 #(.WIDTH(W)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .START (START),
      .A     (A),
      .B     (B),
      .BI    (BI),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .DIFF  (DIFF),
      .BOUT  (BOUT)
`ifdef SUB_SERIAL2_ZERO_FLAG_EN
      ,
      .ZERO  (ZERO)
`endif
   );

   always #5 CLK = ~CLK;

   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
      return {1'b0, a} + {1'b0, ~b} + (W+1)'(bi);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one request at a negedge; returns just after the accept edge with inputs scrambled.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, input bit push);
      @(negedge CLK);
      A = a; B = b; BI = bi; START = 1'b1;
      if (push) sb_q.push_back(model(a, b, bi));
      @(posedge CLK);
      #1;
      START = 1'b0;
      A = 16'($urandom);
      B = 16'($urandom);
      BI = 1'($urandom);
   endtask

   task automatic wait_done(input string tag, input int budget, output int lat);
      bit found;
      logic [W:0] e;
      found = 1'b0;
      lat = 0;
      while (lat < budget && !found) begin
         @(negedge CLK);
         lat++;
         if (DONE) found = 1'b1;
      end
      check({tag, "_done_seen"}, 32'(found), 32'd1);
      if (found && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check({tag, "_diff"}, 32'(DIFF), 32'(e[W-1:0]));
         check({tag, "_bout"}, 32'(BOUT), 32'(e[W]));
      end
   endtask

   task automatic count_dones(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge CLK);
         if (DONE) n++;
      end
   endtask

   initial begin
      int lat, n;
      logic [W-1:0] held;

      // Reset state
      repeat (2) @(negedge CLK);
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_done", 32'(DONE), 32'd0);
      check("rst_diff", 32'(DIFF), 32'd0);
      check("rst_bout", 32'(BOUT), 32'd0);
      RST = 1'b0;

      // Basic op and latency: DONE seen at the 9th edge after the accept edge
      start_op(16'h0005, 16'h0003, 1'b1, 1'b1);
      wait_done("op5m3", 30, lat);
      check("op5m3_lat", 32'(lat), 32'(W/2 + 1));
      @(negedge CLK);
      check("op5m3_pulse", 32'(DONE), 32'd0);

      start_op(16'h0003, 16'h0005, 1'b1, 1'b1);
      wait_done("op3m5", 30, lat);
      start_op(16'h0000, 16'h0000, 1'b0, 1'b1);
      wait_done("op0m0", 30, lat);
      start_op(16'hFFFF, 16'h0000, 1'b1, 1'b1);
      wait_done("opmax", 30, lat);
      start_op(16'hA5C3, 16'h3C5A, 1'b0, 1'b1);
      wait_done("opmix", 30, lat);

      // Result held through IDLE
      held = 16'hA5C3 + ~16'h3C5A;
      repeat (4) @(negedge CLK);
      check("idle_hold_diff", 32'(DIFF), 32'(held));
      check("idle_busy", 32'(BUSY), 32'd0);

      // START during RUN is ignored
      start_op(16'h1000, 16'h0001, 1'b1, 1'b1);
      repeat (3) @(negedge CLK);
      check("run_busy", 32'(BUSY), 32'd1);
      A = 16'hAAAA; B = 16'h5555; BI = 1'b0; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      wait_done("ignore", 30, lat);
      count_dones(14, n);
      check("ignore_no_extra_done", 32'(n), 32'd0);

      // Reset mid-RUN discards the operation
      start_op(16'h00FF, 16'h0000, 1'b1, 1'b0);
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      check("midrst_busy", 32'(BUSY), 32'd0);
      check("midrst_done", 32'(DONE), 32'd0);
      check("midrst_diff", 32'(DIFF), 32'd0);
      check("midrst_bout", 32'(BOUT), 32'd0);
      count_dones(12, n);
      check("midrst_no_done", 32'(n), 32'd0);
      start_op(16'h8000, 16'h0001, 1'b1, 1'b1);
      wait_done("after_rst", 30, lat);

      // RST has priority over START in the same cycle
      @(negedge CLK);
      RST = 1'b1; START = 1'b1; A = 16'h1111; B = 16'h2222; BI = 1'b1;
      @(negedge CLK);
      RST = 1'b0; START = 1'b0;
      check("rst_prio_busy", 32'(BUSY), 32'd0);

      // START held high: back-to-back ops, DONE every WIDTH/2+2 cycles
      @(negedge CLK);
      A = 16'($urandom); B = 16'($urandom); BI = 1'($urandom); START = 1'b1;
      sb_q.push_back(model(A, B, BI));
      wait_done("b2b0", 30, lat);
      check("b2b0_lat", 32'(lat), 32'(W/2 + 1));
      for (int k = 1; k < 3; k++) begin
         A = 16'($urandom); B = 16'($urandom); BI = 1'($urandom);
         sb_q.push_back(model(A, B, BI));
         wait_done("b2b", 30, lat);
         check("b2b_spacing", 32'(lat), 32'(W/2 + 2));
      end
      START = 1'b0;

`ifdef SUB_SERIAL2_ZERO_FLAG_EN
      start_op(16'h1234, 16'h1234, 1'b1, 1'b1);
      wait_done("zero1", 30, lat);
      check("zero_set", 32'(ZERO), 32'd1);
      start_op(16'h1235, 16'h1234, 1'b1, 1'b1);
      wait_done("zero0", 30, lat);
      check("zero_clr", 32'(ZERO), 32'd0);
`endif

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sub_serial2.md
SUB_SERIAL2 -- requirements
Module: sub_serial2

Interface
REQ-001 Parameter: WIDTH, default 16, operand width in bits; SHALL be even and >= 2.
REQ-002 Port: CLK  input  1  the only clock; all state updates on rising edge.
REQ-003 Port: RST  input  1  synchronous, active-high reset.
REQ-004 Port: START  input  1  request; sampled only in IDLE.
REQ-005 Port: A  input  WIDTH  minuend, captured on accepted START.
REQ-006 Port: B  input  WIDTH  subtrahend, captured on accepted START.
REQ-007 Port: BI  input  1  active-low borrow-in (1 = no borrow), captured on accepted START.
REQ-008 Port: BUSY  output  1  high in RUN and DONE states.
REQ-009 Port: DONE  output  1  one-cycle pulse; DIFF/BOUT valid.
REQ-010 Port: DIFF  output  WIDTH  result, held from DONE until the next accepted START.
REQ-011 Port: BOUT  output  1  active-low borrow-out (1 = no borrow), held like DIFF.

Function
REQ-012 Arithmetic: DIFF = (A + ~B + BI) mod 2^WIDTH; BOUT = carry out of that sum.
REQ-013 Digit-serial: 2 bits per cycle, LSB pair first, borrow registered between cycles.
REQ-014 FSM states IDLE, RUN, FIN; reset state IDLE.
REQ-015 IDLE: START=1 -> capture A, B into shift registers, borrow register <= BI, digit counter <= 0, go RUN.
REQ-016 RUN: each cycle process one 2-bit digit, shift result into DIFF from MSB side, increment counter; after WIDTH/2 RUN cycles go FIN.
REQ-017 FIN: DONE=1 for exactly this cycle, DIFF/BOUT final; next cycle IDLE.
REQ-018 Latency: accepted START at edge n -> DONE high in cycle n+WIDTH/2+1.
REQ-019 START while BUSY (RUN or FIN) SHALL be ignored, no queuing.
REQ-020 START held high continuously: a new operation is accepted on each IDLE cycle, i.e. one op every WIDTH/2+2 cycles.
REQ-021 A, B, BI changes after capture SHALL NOT affect the result in progress.
REQ-022 DIFF/BOUT SHALL NOT change in IDLE; DIFF register holds partial results during RUN (not valid).

Reset
REQ-023 RST=1 at any edge, including mid-RUN/FIN: FSM -> IDLE, BUSY=0, DONE=0, DIFF=0, BOUT=0, counter=0, borrow register=0; operation in progress is discarded.
REQ-024 RST has priority over START in the same cycle.

Configuration
REQ-025 Macro SUB_SERIAL2_ZERO_FLAG_EN defined: extra output ZERO (1 bit) = 1 when DIFF == 0, registered, updated in FIN with DIFF, reset 0.
REQ-026 Macro undefined: ZERO port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-027 Shared package: FSM state encoding (IDLE/RUN/FIN) and digit-width constant 2.
REQ-028 One sub-module sub2_slice: combinational 2-bit subtract slice (A[1:0], B[1:0], active-low borrow-in -> 2 result bits, per-bit borrow-outs), instanced once.

Verification
REQ-029 WIDTH=16, A=0x0005, B=0x0003, BI=1, START -> DONE 9 cycles after START edge, DIFF=0x0002, BOUT=1.
REQ-030 A=0x0003, B=0x0005, BI=1 -> DIFF=0xFFFE, BOUT=0; A=0x0000, B=0x0000, BI=0 -> DIFF=0xFFFF, BOUT=0.
REQ-031 START pulsed again during RUN with different operands -> ignored; first result returned; single DONE pulse.
REQ-032 RST asserted 3 cycles into RUN -> next cycle BUSY=0, DIFF=0, BOUT=0, no DONE; new START then completes correctly.
REQ-033 START held high, 3 back-to-back random ops -> DONE spacing exactly 10 cycles, results match REQ-012 model.
REQ-034 With SUB_SERIAL2_ZERO_FLAG_EN: A=B=0x1234, BI=1 -> DIFF=0, BOUT=1, ZERO=1 at DONE; A=0x1235 -> ZERO=0.
